// File: rtl/pool_window_buffer_pkg.sv
// Shared definitions for the 2x2 pooling window buffer.
//   DEF_DATA_WIDTH : default signed pixel width
//   POOL_WIN       : window element count (2*2), the POOL_ constant of the buffer
//   pool_state_e   : FILL (even row, loading the line buffer) / PAIR (odd row, emitting windows)
package pool_window_buffer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned POOL_WIN       = 2 * 2;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } pool_state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer for the pooling window buffer.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write column
//   wr_data_i  : pixel to store
//   rd_addr_i  : even column of the adjacent pair to read
//   rd_even_o  : entry rd_addr_i (combinational read)
//   rd_odd_o   : entry rd_addr_i+1 (combinational read)
module pool_line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 28,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [AW-1:0]                wr_addr_i,
  input  logic signed [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]                rd_addr_i,
  output logic signed [DATA_WIDTH-1:0] rd_even_o,
  output logic signed [DATA_WIDTH-1:0] rd_odd_o
);

  // Storage is never reset: every entry is rewritten before it is read.
  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_even_o = mem_q[rd_addr_i];
  assign rd_odd_o  = mem_q[rd_addr_i + AW'(1)];

endmodule

// File: rtl/pool_window_buffer.sv
// Raster-order pixel stream to 2x2 non-overlapping pooling windows (stride 2, floor).
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : upstream pixel valid
//   in_data    : raster-order signed pixel
//   in_ready   : pixel accepted on in_valid & in_ready (combinational)
//   win_valid  : window valid (registered)
//   win_data   : window {top-left, top-right, bottom-left, bottom-right}
//   win_ready  : downstream accepts on win_valid & win_ready
//   win_last   : marks the final window of a frame
module pool_window_buffer
  import pool_window_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IFM_COLS   = 28,
  parameter int unsigned IFM_ROWS   = 28,
  parameter int unsigned POOL_      = POOL_WIN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         win_valid,
  output logic signed [DATA_WIDTH-1:0] win_data [POOL_],
  input  logic                         win_ready,
  output logic                         win_last
);

  localparam int unsigned COL_W        = $clog2(IFM_COLS);
  localparam int unsigned ROW_W        = $clog2(IFM_ROWS);
  localparam int unsigned LAST_WIN_COL = 2 * (IFM_COLS / 2) - 1;
  localparam int unsigned LAST_WIN_ROW = 2 * (IFM_ROWS / 2) - 1;

  pool_state_e                  state_q, state_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic signed [DATA_WIDTH-1:0] held_q, held_d;
  logic                         win_valid_q, win_valid_d;
  logic                         win_last_q, win_last_d;
  logic signed [DATA_WIDTH-1:0] win_data_q [POOL_];
  logic signed [DATA_WIDTH-1:0] win_data_d [POOL_];

  logic                         in_fire, win_fire, last_col, last_row;
  logic                         lb_wr_en;
  logic [COL_W-1:0]             lb_rd_addr;
  logic signed [DATA_WIDTH-1:0] lb_rd_even, lb_rd_odd;

  assign in_ready   = !win_valid_q || win_ready;
  assign in_fire    = in_valid && in_ready;
  assign win_fire   = win_valid_q && win_ready;
  assign last_col   = (col_q == COL_W'(IFM_COLS - 1));
  assign last_row   = (row_q == ROW_W'(IFM_ROWS - 1));
  assign lb_wr_en   = in_fire && (state_q == FILL);
  // Top pair of the window always starts at the even column below the current one.
  assign lb_rd_addr = col_q & ~COL_W'(1);

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IFM_COLS)
  ) u_line_buffer (
    .clk       (clk),
    .wr_en_i   (lb_wr_en),
    .wr_addr_i (col_q),
    .wr_data_i (in_data),
    .rd_addr_i (lb_rd_addr),
    .rd_even_o (lb_rd_even),
    .rd_odd_o  (lb_rd_odd)
  );

  // Next-state: raster counters, row-parity FSM, held pixel and window register.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    held_d      = held_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    for (int i = 0; i < int'(POOL_); i++) begin
      win_data_d[i] = win_data_q[i];
    end

    if (win_fire) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end

    if (in_fire) begin
      col_d = last_col ? '0 : col_q + COL_W'(1);
      if (last_col) begin
        row_d = last_row ? '0 : row_q + ROW_W'(1);
        // Frame end always returns to FILL, even when an odd last row was in FILL.
        state_d = (last_row || (state_q == PAIR)) ? FILL : PAIR;
      end
      if (state_q == PAIR) begin
        if (!col_q[0]) begin
          held_d = in_data;
        end else begin
          win_valid_d   = 1'b1;
          win_data_d[0] = lb_rd_even;
          win_data_d[1] = lb_rd_odd;
          win_data_d[2] = held_q;
          win_data_d[3] = in_data;
          win_last_d    = (row_q == ROW_W'(LAST_WIN_ROW)) &&
                          (col_q == COL_W'(LAST_WIN_COL));
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      held_q      <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      for (int i = 0; i < int'(POOL_); i++) begin
        win_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      held_q      <= held_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      for (int i = 0; i < int'(POOL_); i++) begin
        win_data_q[i] <= win_data_d[i];
      end
    end
  end

  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign win_data  = win_data_q;

endmodule
